// File: rtl/cache_pkg.sv
// cache_pkg: FSM states and geometry helpers shared by the set-associative cache controller
package cache_pkg;
  typedef enum logic [2:0] {IDLE, TAG_CHECK, WRITEBACK, REFILL_REQ, REFILL_WAIT, RESPONSE} state_t;
  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction
  function automatic int age_w(input int ways);
    return $clog2(ways);
  endfunction
  function automatic int tag_w(input int addr_w, input int sets);
    return addr_w - $clog2(sets);
  endfunction
endpackage

// File: rtl/cache_ctrl_sa_if.sv
// cache_ctrl_sa_if: CPU request/response and main-memory bus of the cache controller
interface cache_ctrl_sa_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int CNT_W = 16
);
  logic req_valid, req_ready, req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic rsp_valid, rsp_hit;
  logic [DATA_W-1:0] rsp_rdata;
  logic mem_req_valid, mem_req_ready, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic mem_rsp_valid;
  logic [DATA_W-1:0] mem_rdata;
  logic [CNT_W-1:0] hit_count, miss_count;
  modport slave (
    input req_valid, req_we, req_addr, req_wdata, mem_req_ready, mem_rsp_valid, mem_rdata,
    output req_ready, rsp_valid, rsp_hit, rsp_rdata, mem_req_valid, mem_we, mem_addr, mem_wdata,
    hit_count, miss_count
  );
  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_req_ready, mem_rsp_valid, mem_rdata,
    input req_ready, rsp_valid, rsp_hit, rsp_rdata, mem_req_valid, mem_we, mem_addr, mem_wdata,
    hit_count, miss_count
  );
endinterface

// File: rtl/cache_lru.sv
// cache_lru: true-LRU age update on touch and victim select (invalid-first, then oldest) for one set
module cache_lru #(
  parameter int WAYS = 4,
  parameter int AGE_W = 2
) (
  input  logic [WAYS-1:0][AGE_W-1:0] age,
  input  logic [WAYS-1:0]            valid,
  input  logic [AGE_W-1:0]           touch,
  output logic [WAYS-1:0][AGE_W-1:0] age_nxt,
  output logic [AGE_W-1:0]           victim
);
  always_comb begin
    age_nxt = age;
    victim = '0;
    for (int i = WAYS - 1; i >= 0; i--) victim = (age[i] == AGE_W'(WAYS - 1)) ? AGE_W'(i) : victim;
    // descending scan so the lowest-index invalid way wins over the oldest
    for (int i = WAYS - 1; i >= 0; i--) victim = !valid[i] ? AGE_W'(i) : victim;
    for (int i = 0; i < WAYS; i++)
      age_nxt[i] = (AGE_W'(i) == touch) ? '0 : (age[i] < age[touch]) ? age[i] + 1'b1 : age[i];
  end
endmodule

// File: rtl/cache_ctrl_sa.sv
// cache_ctrl_sa: set-associative write-back cache controller with true-LRU replacement,
// dirty-victim writeback, ready/valid refill and saturating hit/miss counters
module cache_ctrl_sa
  import cache_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int SETS = 4,
  parameter int WAYS = 4,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  cache_ctrl_sa_if.slave bus
);
  localparam int IDX_W = idx_w(SETS);
  localparam int AGE_W = age_w(WAYS);
  localparam int TAG_W = tag_w(ADDR_W, SETS);
  state_t state;
  logic cap_we;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  logic [AGE_W-1:0] way_q, hit_way, victim;
  logic hit;
  logic [SETS-1:0][WAYS-1:0] valid_q, dirty_q;
  logic [SETS-1:0][WAYS-1:0][AGE_W-1:0] age_q;
  logic [WAYS-1:0][AGE_W-1:0] age_nxt;
  logic [TAG_W-1:0] tag_q [SETS][WAYS];
  logic [DATA_W-1:0] data_q [SETS][WAYS];
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tg;
  assign idx = cap_addr[IDX_W-1:0];
  assign tg = cap_addr[ADDR_W-1:IDX_W];
  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    for (int i = 0; i < WAYS; i++)
      if (valid_q[idx][i] && tag_q[idx][i] == tg) begin
        hit = 1'b1;
        hit_way = AGE_W'(i);
      end
  end
  cache_lru #(.WAYS(WAYS), .AGE_W(AGE_W)) u_lru (
    .age(age_q[idx]), .valid(valid_q[idx]), .touch(way_q), .age_nxt(age_nxt), .victim(victim)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_hit <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.mem_req_valid <= 1'b0;
      bus.mem_we <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_wdata <= '0;
      bus.hit_count <= '0;
      bus.miss_count <= '0;
      cap_we <= 1'b0;
      cap_addr <= '0;
      cap_wdata <= '0;
      way_q <= '0;
      valid_q <= '0;
      dirty_q <= '0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= AGE_W'(w);
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state)
        IDLE: if (bus.req_valid) begin
          cap_we <= bus.req_we;
          cap_addr <= bus.req_addr;
          cap_wdata <= bus.req_wdata;
          bus.req_ready <= 1'b0;
          state <= TAG_CHECK;
        end
        TAG_CHECK: if (hit) begin
          way_q <= hit_way;
          bus.hit_count <= &bus.hit_count ? bus.hit_count : bus.hit_count + 1'b1;
          bus.rsp_valid <= 1'b1;
          bus.rsp_hit <= 1'b1;
          bus.rsp_rdata <= cap_we ? '0 : data_q[idx][hit_way];
          state <= RESPONSE;
        end else begin
          way_q <= victim;
          bus.miss_count <= &bus.miss_count ? bus.miss_count : bus.miss_count + 1'b1;
          if (valid_q[idx][victim] && dirty_q[idx][victim]) begin
            bus.mem_req_valid <= 1'b1;
            bus.mem_we <= 1'b1;
            bus.mem_addr <= {tag_q[idx][victim], idx};
            bus.mem_wdata <= data_q[idx][victim];
            state <= WRITEBACK;
          end else if (cap_we) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_rdata <= '0;
            state <= RESPONSE;
          end else begin
            bus.mem_req_valid <= 1'b1;
            bus.mem_we <= 1'b0;
            bus.mem_addr <= cap_addr;
            state <= REFILL_REQ;
          end
        end
        WRITEBACK: if (bus.mem_req_ready) begin
          bus.mem_we <= 1'b0;
          bus.mem_addr <= cap_addr;
          bus.mem_req_valid <= !cap_we;
          bus.rsp_valid <= cap_we;
          bus.rsp_rdata <= '0;
          state <= cap_we ? RESPONSE : REFILL_REQ;
        end
        REFILL_REQ: if (bus.mem_req_ready) begin
          bus.mem_req_valid <= 1'b0;
          state <= REFILL_WAIT;
        end
        REFILL_WAIT: if (bus.mem_rsp_valid) begin
          valid_q[idx][way_q] <= 1'b1;
          dirty_q[idx][way_q] <= 1'b0;
          bus.rsp_valid <= 1'b1;
          bus.rsp_rdata <= bus.mem_rdata;
          state <= RESPONSE;
        end
        RESPONSE: begin
          age_q[idx] <= age_nxt;
          if (cap_we) begin
            valid_q[idx][way_q] <= 1'b1;
            dirty_q[idx][way_q] <= 1'b1;
          end
          bus.rsp_hit <= 1'b0;
          bus.rsp_rdata <= '0;
          bus.req_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  // tag/data arrays are deliberately left out of reset; valid bits gate their use
  always_ff @(posedge clk) begin
    if (state == REFILL_WAIT && bus.mem_rsp_valid) begin
      tag_q[idx][way_q] <= tg;
      data_q[idx][way_q] <= bus.mem_rdata;
    end
    if (state == RESPONSE && cap_we) begin
      tag_q[idx][way_q] <= tg;
      data_q[idx][way_q] <= cap_wdata;
    end
  end
endmodule

// File: tb/tb_cache_ctrl_sa.sv
// tb_cache_ctrl_sa: randomized self-checking bench against a recency-list cache model
module tb_cache_ctrl_sa;
  localparam int ADDR_W = 16, DATA_W = 32, SETS = 4, WAYS = 4, CNT_W = 16;
  localparam int IDX_W = 2, TAG_W = ADDR_W - IDX_W;
  typedef struct {bit we; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data;} mtx_t;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  cache_ctrl_sa_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();
  cache_ctrl_sa #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SETS(SETS), .WAYS(WAYS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  int checks = 0, failures = 0;
  bit auto_mem = 1;
  int ready_delay = 0;
  logic a_ready = 0, a_rsp_valid = 0, m_ready = 0, m_rsp_valid = 0;
  logic [DATA_W-1:0] a_rdata = '0, m_rdata = '0;
  assign bus.mem_req_ready = auto_mem ? a_ready : m_ready;
  assign bus.mem_rsp_valid = auto_mem ? a_rsp_valid : m_rsp_valid;
  assign bus.mem_rdata = auto_mem ? a_rdata : m_rdata;
  logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];
  mtx_t mlog[$];
  logic [TAG_W-1:0] m_tag [SETS][WAYS];
  logic [DATA_W-1:0] m_data [SETS][WAYS];
  bit m_val [SETS][WAYS];
  bit m_dirty [SETS][WAYS];
  int m_order [SETS][$];
  int m_hits, m_misses;

  function automatic logic [DATA_W-1:0] mem_rd(input logic [ADDR_W-1:0] a);
    return mem.exists(a) ? mem[a] : {a ^ 16'hA5A5, a};
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < SETS; s++) begin
      m_order[s].delete();
      for (int w = 0; w < WAYS; w++) begin
        m_val[s][w] = 0;
        m_dirty[s][w] = 0;
        m_order[s].push_back(w);
      end
    end
    m_hits = 0;
    m_misses = 0;
  endfunction

  // recency list per set, most recent first; victim = first invalid way, else list tail
  function automatic void model_access(input bit we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                                       output bit hit, output logic [DATA_W-1:0] rd, output mtx_t ex[$]);
    int s, w, pos;
    logic [TAG_W-1:0] t;
    s = int'(a % SETS);
    t = TAG_W'(a / SETS);
    w = -1;
    ex.delete();
    for (int i = 0; i < WAYS; i++) if (m_val[s][i] && m_tag[s][i] == t) w = i;
    hit = (w >= 0);
    if (hit) m_hits = (m_hits < 65535) ? m_hits + 1 : m_hits;
    else begin
      m_misses = (m_misses < 65535) ? m_misses + 1 : m_misses;
      for (int i = WAYS - 1; i >= 0; i--) if (!m_val[s][i]) w = i;
      if (w < 0) w = m_order[s][$];
      if (m_val[s][w] && m_dirty[s][w]) ex.push_back('{1'b1, {m_tag[s][w], IDX_W'(s)}, m_data[s][w]});
      if (!we) begin
        ex.push_back('{1'b0, a, '0});
        m_data[s][w] = mem_rd(a);
        m_dirty[s][w] = 0;
      end
      m_val[s][w] = 1;
      m_tag[s][w] = t;
    end
    if (we) begin
      m_data[s][w] = d;
      m_dirty[s][w] = 1;
    end
    rd = we ? '0 : m_data[s][w];
    pos = 0;
    for (int i = 0; i < m_order[s].size(); i++) if (m_order[s][i] == w) pos = i;
    m_order[s].delete(pos);
    m_order[s].push_front(w);
  endfunction

  initial begin
    int wait_cnt, rsp_wait;
    logic [ADDR_W-1:0] rsp_addr;
    wait_cnt = 0;
    rsp_wait = -1;
    rsp_addr = '0;
    forever begin
      @(negedge clk);
      a_ready = 0;
      a_rsp_valid = 0;
      if (!auto_mem || rst) begin
        wait_cnt = 0;
        rsp_wait = -1;
      end else begin
        if (rsp_wait == 0) begin
          a_rsp_valid = 1;
          a_rdata = mem_rd(rsp_addr);
          rsp_wait = -1;
        end else if (rsp_wait > 0) rsp_wait--;
        if (bus.mem_req_valid) begin
          if (wait_cnt >= ready_delay) begin
            a_ready = 1;
            mlog.push_back('{bus.mem_we, bus.mem_addr, bus.mem_wdata});
            if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
            else begin
              rsp_addr = bus.mem_addr;
              rsp_wait = $urandom_range(0, 3);
            end
            wait_cnt = 0;
          end else wait_cnt++;
        end
      end
    end
  end

  task automatic do_req(input bit we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input string nm,
                        output int lat, output bit got_hit);
    bit eh;
    logic [DATA_W-1:0] er;
    mtx_t ex[$];
    int n;
    model_access(we, a, d, eh, er, ex);
    mlog.delete();
    @(negedge clk);
    n = 0;
    while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
    bus.req_valid = 1; bus.req_we = we; bus.req_addr = a; bus.req_wdata = d;
    @(negedge clk);
    bus.req_valid = 0;
    lat = 0;
    while (!bus.rsp_valid && lat < 300) begin @(negedge clk); lat++; end
    got_hit = bus.rsp_hit;
    checks++;
    if (bus.rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s rsp_valid timeout: got %b after %0d cycles, want 1", nm, bus.rsp_valid, lat);
    end else begin
      checks++;
      if (bus.rsp_hit !== eh) begin failures++; $display("FAIL %s rsp_hit got %b want %b", nm, bus.rsp_hit, eh); end
      checks++;
      if (bus.rsp_rdata !== er) begin failures++; $display("FAIL %s rsp_rdata got %h want %h", nm, bus.rsp_rdata, er); end
      checks++;
      if (bus.hit_count !== CNT_W'(m_hits)) begin failures++; $display("FAIL %s hit_count got %0d want %0d", nm, bus.hit_count, m_hits); end
      checks++;
      if (bus.miss_count !== CNT_W'(m_misses)) begin failures++; $display("FAIL %s miss_count got %0d want %0d", nm, bus.miss_count, m_misses); end
      checks++;
      if (mlog.size() != ex.size()) begin
        failures++;
        $display("FAIL %s mem transactions got %0d want %0d", nm, mlog.size(), ex.size());
      end else
        for (int i = 0; i < ex.size(); i++) begin
          checks++;
          if (mlog[i].we !== ex[i].we || mlog[i].addr !== ex[i].addr || (ex[i].we && mlog[i].data !== ex[i].data)) begin
            failures++;
            $display("FAIL %s mem tx %0d got we=%b addr=%h data=%h want we=%b addr=%h data=%h", nm, i,
                     mlog[i].we, mlog[i].addr, mlog[i].data, ex[i].we, ex[i].addr, ex[i].data);
          end
        end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.mem_req_valid !== 1'b0 || bus.mem_we !== 1'b0 ||
        bus.rsp_hit !== 1'b0 || bus.mem_addr !== '0 || bus.rsp_rdata !== '0) begin
      failures++;
      $display("FAIL reset outputs got ready=%b rsp=%b mreq=%b mwe=%b hit=%b maddr=%h want 1,0,0,0,0,0",
               bus.req_ready, bus.rsp_valid, bus.mem_req_valid, bus.mem_we, bus.rsp_hit, bus.mem_addr);
    end
    checks++;
    if (bus.hit_count !== '0 || bus.miss_count !== '0) begin
      failures++;
      $display("FAIL reset counters got %0d/%0d want 0/0", bus.hit_count, bus.miss_count);
    end
    rst = 0;
  endtask

  task automatic test_read_miss_hit();
    int lat;
    bit h;
    mem[16'h0010] = 32'hCAFE0001;
    do_req(1'b0, 16'h0010, '0, "read_miss", lat, h);
    checks++;
    if (bus.rsp_rdata !== 32'hCAFE0001) begin failures++; $display("FAIL read_miss data got %h want cafe0001", bus.rsp_rdata); end
    do_req(1'b0, 16'h0010, '0, "read_hit", lat, h);
  endtask

  task automatic test_write_cold();
    int lat;
    bit h;
    do_req(1'b1, 16'h0020, 32'h12345678, "write_cold", lat, h);
    do_req(1'b0, 16'h0020, '0, "read_after_write", lat, h);
    checks++;
    if (bus.rsp_rdata !== 32'h12345678) begin failures++; $display("FAIL read_after_write got %h want 12345678", bus.rsp_rdata); end
  endtask

  task automatic test_writeback();
    int lat;
    bit h;
    for (int i = 1; i <= 4; i++) do_req(1'b1, ADDR_W'(i * 256 + 3), DATA_W'(32'h11110000 + i), "fill_set", lat, h);
    do_req(1'b1, 16'h0503, 32'h55555555, "evict_dirty", lat, h);
    checks++;
    if (mlog.size() == 0 || mlog[0].we !== 1'b1 || mlog[0].addr !== 16'h0103 || mlog[0].data !== 32'h11110001) begin
      failures++;
      $display("FAIL evict_dirty writeback got %0d txs first addr=%h want addr=0103 data=11110001", mlog.size(),
               mlog.size() > 0 ? mlog[0].addr : 16'h0);
    end
  endtask

  task automatic test_lru_order();
    int lat;
    bit h;
    for (int i = 1; i <= 4; i++) do_req(1'b0, ADDR_W'(i * 256 + 2), '0, "lru_fill", lat, h);
    do_req(1'b0, 16'h0102, '0, "lru_retouch", lat, h);
    do_req(1'b0, 16'h0502, '0, "lru_evict", lat, h);
    do_req(1'b0, 16'h0102, '0, "lru_keep_way0", lat, h);
    checks++;
    if (h !== 1'b1) begin failures++; $display("FAIL lru_keep_way0 hit got %b want 1", h); end
    do_req(1'b0, 16'h0202, '0, "lru_way1_gone", lat, h);
    checks++;
    if (h !== 1'b0) begin failures++; $display("FAIL lru_way1_gone hit got %b want 0", h); end
  endtask

  task automatic test_stall();
    bit eh;
    logic [DATA_W-1:0] er;
    mtx_t ex[$];
    mem[16'h0011] = 32'h0BADF00D;
    model_access(1'b0, 16'h0011, '0, eh, er, ex);
    auto_mem = 0; m_ready = 0; m_rsp_valid = 0;
    @(negedge clk);
    bus.req_valid = 1; bus.req_we = 0; bus.req_addr = 16'h0011;
    @(negedge clk);
    bus.req_valid = 0;
    @(negedge clk);
    checks++;
    if (bus.mem_req_valid !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 16'h0011) begin
      failures++;
      $display("FAIL stall refill_req got v=%b we=%b addr=%h want 1,0,0011", bus.mem_req_valid, bus.mem_we, bus.mem_addr);
    end
    for (int i = 0; i < 7; i++) begin
      m_rsp_valid = i[0];
      m_rdata = 32'hDEAD0000 + i;
      @(negedge clk);
      checks++;
      if (bus.mem_req_valid !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 16'h0011 || bus.rsp_valid !== 1'b0) begin
        failures++;
        $display("FAIL stall hold cycle %0d got v=%b we=%b addr=%h rsp=%b want 1,0,0011,0", i,
                 bus.mem_req_valid, bus.mem_we, bus.mem_addr, bus.rsp_valid);
      end
    end
    m_rsp_valid = 0; m_ready = 1;
    @(negedge clk);
    m_ready = 0;
    checks++;
    if (bus.mem_req_valid !== 1'b0) begin failures++; $display("FAIL stall accept mem_req_valid got %b want 0", bus.mem_req_valid); end
    @(negedge clk);
    m_rsp_valid = 1; m_rdata = 32'h0BADF00D;
    @(negedge clk);
    m_rsp_valid = 0;
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_hit !== 1'b0 || bus.rsp_rdata !== er) begin
      failures++;
      $display("FAIL stall response got v=%b hit=%b data=%h want 1,0,%h", bus.rsp_valid, bus.rsp_hit, bus.rsp_rdata, er);
    end
    checks++;
    if (bus.miss_count !== CNT_W'(m_misses)) begin failures++; $display("FAIL stall miss_count got %0d want %0d", bus.miss_count, m_misses); end
    auto_mem = 1;
  endtask

  task automatic test_back_to_back();
    int lat;
    bit h;
    for (int i = 0; i < 3; i++) begin
      do_req(1'b0, 16'h0010, '0, "b2b_hit", lat, h);
      checks++;
      if (lat !== 1) begin failures++; $display("FAIL b2b latency got %0d want 1", lat); end
      checks++;
      if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL b2b ready during rsp got %b want 0", bus.req_ready); end
    end
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL b2b ready after rsp got %b want 1", bus.req_ready); end
  endtask

  task automatic test_reset_mid();
    int lat;
    bit h;
    auto_mem = 0; m_ready = 0; m_rsp_valid = 0;
    @(negedge clk);
    bus.req_valid = 1; bus.req_we = 0; bus.req_addr = 16'h0021;
    @(negedge clk);
    bus.req_valid = 0;
    @(negedge clk);
    m_ready = 1;
    @(negedge clk);
    m_ready = 0;
    checks++;
    if (bus.req_ready !== 1'b0 || bus.mem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid pre got ready=%b mreq=%b want 0,0", bus.req_ready, bus.mem_req_valid);
    end
    #2 rst = 1;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1 || bus.mem_req_valid !== 1'b0 || bus.rsp_valid !== 1'b0 ||
        bus.hit_count !== '0 || bus.miss_count !== '0) begin
      failures++;
      $display("FAIL reset_mid async got ready=%b mreq=%b rsp=%b cnt=%0d/%0d want 1,0,0,0/0",
               bus.req_ready, bus.mem_req_valid, bus.rsp_valid, bus.hit_count, bus.miss_count);
    end
    @(negedge clk);
    rst = 0;
    model_reset();
    auto_mem = 1;
    do_req(1'b0, 16'h0021, '0, "reset_mid_reread", lat, h);
    checks++;
    if (h !== 1'b0) begin failures++; $display("FAIL reset_mid_reread hit got %b want 0", h); end
  endtask

  task automatic test_random();
    int lat;
    bit h;
    for (int i = 0; i < 80; i++) begin
      ready_delay = $urandom_range(0, 2);
      do_req(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 23)), DATA_W'($urandom), "random", lat, h);
    end
    ready_delay = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 0; bus.req_we = 0; bus.req_addr = '0; bus.req_wdata = '0;
    model_reset();
    test_reset();
    test_read_miss_hit();
    test_write_cold();
    test_writeback();
    test_lru_order();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
